// File: rtl/zero2one_batch_collector_pkg.sv
// Shared definitions for the zero2one batch collector.
//   zero2one_t     : one element code, stored bit-exact
//   ZERO2ONE_ZERO  : reset / cleared value of an element
//   batch_state_e  : per-bank state (BATCH_FILL / BATCH_FULL)
package zero2one_batch_collector_pkg;

    localparam int ZERO2ONE_W = 8;

    typedef logic [ZERO2ONE_W-1:0] zero2one_t;

    localparam zero2one_t ZERO2ONE_ZERO = '0;

    typedef enum logic {
        BATCH_FILL = 1'b0,
        BATCH_FULL = 1'b1
    } batch_state_e;

endpackage

// File: rtl/zero2one_batch_collector_bank.sv
// zero2one_batch_bank: one N x LEN storage bank with its own fill state.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   we, idx, vec: write port (row idx <= vec when we and bank is filling)
//   clr         : drop the partial fill (count back to 0); ignored when FULL
//   consume     : release a FULL bank back to FILL
//   full        : bank holds N rows awaiting consume
//   count       : rows written in the current fill
//   batch       : stored rows, row k = k-th write of the fill
module zero2one_batch_bank
    import zero2one_batch_collector_pkg::*;
#(
    parameter  int N   = 16,
    parameter  int LEN = 32,
    localparam int IW  = $clog2(N),
    localparam int CW  = $clog2(N + 1)
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              we,
    input  logic [IW-1:0]                     idx,
    input  zero2one_t [LEN-1:0]               vec,
    input  logic                              clr,
    input  logic                              consume,
    output logic                              full,
    output logic [CW-1:0]                     count,
    output zero2one_t [N-1:0][LEN-1:0]        batch
);

    batch_state_e        state_reg, state_next;
    logic [CW-1:0]       count_reg, count_next;
    logic                last_row;
    logic                wr_ok;
    logic [N-1:0]        row_we;
    zero2one_t [LEN-1:0] mem_reg [N];

    assign last_row = (count_reg == CW'(N - 1));
    // A clear wins over a write in the same cycle; a FULL bank never writes.
    assign wr_ok    = we && !clr && (state_reg == BATCH_FILL);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= BATCH_FILL;
            count_reg <= '0;
        end else begin
            state_reg <= state_next;
            count_reg <= count_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        count_next = count_reg;
        case (state_reg)
            BATCH_FILL: begin
                if (clr) begin
                    count_next = '0;
                end else if (we) begin
                    if (last_row) begin
                        count_next = '0;
                        state_next = BATCH_FULL;
                    end else begin
                        count_next = count_reg + CW'(1);
                    end
                end
            end
            BATCH_FULL: begin
                if (consume) begin
                    state_next = BATCH_FILL;
                end
            end
            default: state_next = BATCH_FILL;
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_row
            assign row_we[gi] = wr_ok && (idx == IW'(gi));

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    mem_reg[gi] <= {LEN{ZERO2ONE_ZERO}};
                end else if (row_we[gi]) begin
                    mem_reg[gi] <= vec;
                end
            end

            assign batch[gi] = mem_reg[gi];
        end
    endgenerate

    assign full  = (state_reg == BATCH_FULL);
    assign count = count_reg;

endmodule

// File: rtl/zero2one_batch_collector.sv
// zero2one_batch_collector: gathers N zero2one_t vectors (one per accept)
// into a batch and presents the whole [N-1:0][LEN-1:0] array downstream.
// Ports:
//   clk, rst_n           : clock, asynchronous active-low reset
//   in_valid/in_ready    : input handshake, in_vec is the sample
//   flush                : drop the partial batch of the filling bank
//   out_valid/out_ready  : output handshake, out_batch is the batch
//   fill_count           : samples held in the filling bank
// Build option: define ZERO2ONE_BATCH_PINGPONG_EN for two banks, so filling
// continues while the other bank waits to be consumed.
module zero2one_batch_collector
    import zero2one_batch_collector_pkg::*;
#(
    parameter  int N   = 16,
    parameter  int LEN = 32,
    localparam int IW  = $clog2(N),
    localparam int CW  = $clog2(N + 1)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  zero2one_t [LEN-1:0]        in_vec,
    input  logic                       flush,
    output logic                       out_valid,
    input  logic                       out_ready,
    output zero2one_t [N-1:0][LEN-1:0] out_batch,
    output logic [CW-1:0]              fill_count
);

`ifdef ZERO2ONE_BATCH_PINGPONG_EN
    localparam int NB = 2;
`else
    localparam int NB = 1;
`endif

    logic [NB-1:0]              wr_oh;
    logic [NB-1:0]              rd_oh;
    logic [NB-1:0]              bank_full;
    logic [NB-1:0]              bank_we;
    logic [NB-1:0]              bank_clr;
    logic [NB-1:0]              bank_consume;
    logic [CW-1:0]              bank_count [NB];
    zero2one_t [N-1:0][LEN-1:0] bank_data  [NB];

    logic wr_full;
    logic accept;
    logic consume;

    assign in_ready = !wr_full && !flush;
    assign accept   = in_valid && in_ready;
    assign consume  = out_valid && out_ready;

    assign bank_we      = {NB{accept}}  & wr_oh;
    assign bank_clr     = {NB{flush}}   & wr_oh;
    assign bank_consume = {NB{consume}} & rd_oh;

    genvar gi;
    generate
        for (gi = 0; gi < NB; gi++) begin : g_bank
            zero2one_batch_bank #(
                .N   (N),
                .LEN (LEN)
            ) u_bank (
                .clk     (clk),
                .rst_n   (rst_n),
                .we      (bank_we[gi]),
                .idx     (bank_count[gi][IW-1:0]),
                .vec     (in_vec),
                .clr     (bank_clr[gi]),
                .consume (bank_consume[gi]),
                .full    (bank_full[gi]),
                .count   (bank_count[gi]),
                .batch   (bank_data[gi])
            );
        end
    endgenerate

`ifdef ZERO2ONE_BATCH_PINGPONG_EN
    // Banks complete and are consumed in the same order, so each pointer
    // simply toggles on its own event.
    logic wr_ptr_reg, wr_ptr_next;
    logic rd_ptr_reg, rd_ptr_next;
    logic completion;

    assign completion = accept && (fill_count == CW'(N - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= 1'b0;
            rd_ptr_reg <= 1'b0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
        end
    end

    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        if (completion) wr_ptr_next = !wr_ptr_reg;
        if (consume)    rd_ptr_next = !rd_ptr_reg;
    end

    // The write bank can only be FULL when both banks are FULL.
    assign wr_oh      = wr_ptr_reg ? 2'b10 : 2'b01;
    assign rd_oh      = rd_ptr_reg ? 2'b10 : 2'b01;
    assign wr_full    = bank_full[wr_ptr_reg];
    assign out_valid  = bank_full[rd_ptr_reg];
    assign out_batch  = bank_data[rd_ptr_reg];
    assign fill_count = bank_count[wr_ptr_reg];
`else
    assign wr_oh      = 1'b1;
    assign rd_oh      = 1'b1;
    assign wr_full    = bank_full[0];
    assign out_valid  = bank_full[0];
    assign out_batch  = bank_data[0];
    assign fill_count = bank_count[0];
`endif

endmodule

// File: doc/zero2one_batch_collector.md
# zero2one_batch_collector

Sequential front end for the batch averager: accepts one LEN-wide `zero2one_t` vector per valid/ready handshake, buffers N of them, then presents the complete `[N-1:0][LEN-1:0]` array with a valid/ready handshake. Its `out_batch` drives the `in` port of the combinational batch-average stage directly. The downstream stage sees a stable array for as long as `out_valid` is high.

## Interface
- `N`, 16, vectors per batch (≥2)
- `LEN`, 32, elements per vector (≥1)
- `clk` input 1 — single clock, rising edge
- `rst_n` input 1 — asynchronous, active-low reset
- `in_valid` input 1 — `in_vec` holds a valid sample
- `in_ready` output 1 — collector can accept a sample this cycle
- `in_vec` input `zero2one_t [LEN-1:0]` — incoming sample vector
- `flush` input 1 — discard the partially filled batch
- `out_valid` output 1 — `out_batch` holds a complete batch
- `out_ready` input 1 — downstream consumes the batch
- `out_batch` output `zero2one_t [N-1:0][LEN-1:0]` — buffered batch; row k is the k-th accepted sample
- `fill_count` output `$clog2(N+1)` — samples held in the filling bank

## Operation
- Accept occurs when `in_valid && in_ready`. Store `in_vec` at row `wr_idx`, then increment `wr_idx`.
- States per bank: FILL (0..N-1 rows written) and FULL (N rows written, awaiting consume).
- FILL → FULL on the accept that writes row N-1. `wr_idx` wraps to 0.
- FULL → FILL on `out_valid && out_ready`. Row contents are not cleared; they are overwritten by later accepts.
- `in_ready` = filling bank in FILL && !`flush`. It is combinational from state and `flush` only, with no dependence on `in_valid`.
- `out_valid` = 1 when the read bank is FULL. `out_batch` is stable while `out_valid` is high and unconsumed.
- `flush` resets `wr_idx`/`fill_count` of the filling bank to 0 and blocks accepts that cycle. It has no effect on a FULL bank awaiting consume.
- No arithmetic on data; values are stored bit-exact.
- Reset values: state FILL, `wr_idx` 0, `fill_count` 0, `out_valid` 0, all storage `zero2one_t` zero. `in_ready` is 1 from the first cycle after `rst_n` deasserts.
- Reset asserted mid-batch: all partial and full data is lost, and outputs return to reset values asynchronously.

## Timing
- Accept of row N-1 on edge t → `out_valid` = 1 after t, visible in cycle t+1.
- Consume on edge t → `out_valid` = 0 in cycle t+1 (single bank), and `in_ready` = 1 in cycle t+1.
- Without the macro, the minimum period per batch is N accept cycles plus 1 consume cycle. There is no bubble if `out_ready` is high when `out_valid` rises.
- Simultaneous `in_valid` and consume in single-bank mode: cannot occur, because `in_ready` = 0 while FULL.

## Configuration
- `ZERO2ONE_BATCH_PINGPONG_EN`:
  - Defined: two banks, with a write pointer and a read pointer each toggling on completion/consume. `in_ready` is 0 only when both banks are FULL (or `flush`). Filling continues while the other bank is held for output.
  - Same-cycle consume of bank A and completion of bank B → `out_valid` stays 1 and `out_batch` switches to bank B in the next cycle.
  - Sustained throughput is N accepts per N cycles.
- Undefined: one bank, behaviour as above. Storage and logic for the second bank are not built.

## Structure
- `zero2one_t`, its zero constant and the bank-state enum (`BATCH_FILL`, `BATCH_FULL`) live in the shared defs package/header.
- Sub-module `zero2one_batch_bank`: one N×LEN storage bank with write port (`we`, `idx`, `vec`), FULL flag and `count`. The top instantiates one bank, or two under `ZERO2ONE_BATCH_PINGPONG_EN`, plus the pointer/handshake control.

## Test plan
All scenarios use N=4, LEN=2.
- **Reset then 4 accepts** (vectors {1,2},{3,4},{5,6},{7,8} as zero2one codes) → `out_valid` rises the cycle after the 4th accept. `out_batch` rows 0..3 match, `in_ready` = 0 (single bank), `fill_count` = 0.
- **Hold `out_ready` = 0 for 10 cycles, with `in_valid` = 1 throughout** → `out_batch` unchanged, no accept occurs, and `out_valid` stays 1. On `out_ready` = 1 → `out_valid` = 0 and `in_ready` = 1 next cycle.
- **Flush after 2 accepts, together with `in_valid` = 1** → no accept that cycle, `fill_count` = 0. The next 4 accepts form the batch, rows 0..3 = the new vectors.
- **Assert `rst_n` low mid-batch (3 accepts)** → `out_valid` = 0 immediately and `fill_count` = 0. After release, a full batch of 4 is required for `out_valid`.
- **`ZERO2ONE_BATCH_PINGPONG_EN`, continuous `in_valid`, `out_ready` = 1** → an accept every cycle. `out_valid` pulses each 4 cycles with consecutive batches correct.
- **`ZERO2ONE_BATCH_PINGPONG_EN`, `out_ready` held 0** → 8 accepts, then `in_ready` = 0. Releasing `out_ready` yields batch 1, then batch 2, on consecutive cycles.
